// File: rtl/sram_arb_ctrl.sv
// Two-port arbiter and strobe sequencer for the iceFUN external 16-bit async SRAM/PSRAM.
// Define SRAM_ARB_RR_EN for round-robin arbitration; otherwise port A has fixed priority.
module sram_arb_ctrl #(
    parameter int ADDR_W      = 22,
    parameter int DATA_W      = 16,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              a_req,
    input  logic              a_wr,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    input  logic [1:0]        a_be,
    output logic              a_done,
    output logic [DATA_W-1:0] a_rdata,

    input  logic              b_req,
    input  logic              b_wr,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    input  logic [1:0]        b_be,
    output logic              b_done,
    output logic [DATA_W-1:0] b_rdata,

    output logic              mem_ce_n,
    output logic              mem_ce2,
    output logic              mem_we_n,
    output logic              mem_oe_n,
    output logic              mem_lb_n,
    output logic              mem_ub_n,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_dq_oe,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, HOLD} state_t;

    state_t     state;
    logic [3:0] wait_cnt;
    logic       sel_b;
    logic       lat_wr;
    logic       grant_b;

`ifdef SRAM_ARB_RR_EN
    // last_b = 1 means port B held the previous grant, so A wins the next tie.
    logic last_b;

    assign grant_b = b_req & (~a_req | ~last_b);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_b <= 1'b1;
        end else if (state == IDLE && (a_req || b_req)) begin
            last_b <= grant_b;
        end
    end
`else
    assign grant_b = b_req & ~a_req;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            wait_cnt  <= 4'd0;
            sel_b     <= 1'b0;
            lat_wr    <= 1'b0;
            mem_ce_n  <= 1'b1;
            mem_ce2   <= 1'b0;
            mem_we_n  <= 1'b1;
            mem_oe_n  <= 1'b1;
            mem_lb_n  <= 1'b1;
            mem_ub_n  <= 1'b1;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_dq_oe <= 1'b0;
            a_done    <= 1'b0;
            b_done    <= 1'b0;
            a_rdata   <= '0;
            b_rdata   <= '0;
        end else begin
            a_done <= 1'b0;
            b_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (a_req || b_req) begin
                        sel_b                <= grant_b;
                        lat_wr               <= grant_b ? b_wr : a_wr;
                        mem_addr             <= grant_b ? b_addr : a_addr;
                        mem_wdata            <= grant_b ? b_wdata : a_wdata;
                        {mem_ub_n, mem_lb_n} <= ~(grant_b ? b_be : a_be);
                        mem_dq_oe            <= grant_b ? b_wr : a_wr;
                        mem_ce_n             <= 1'b0;
                        mem_ce2              <= 1'b1;
                        state                <= SETUP;
                    end
                end
                SETUP: begin
                    wait_cnt <= 4'(WAIT_CYCLES);
                    mem_we_n <= ~lat_wr;
                    mem_oe_n <= lat_wr;
                    state    <= ACCESS;
                end
                ACCESS: begin
                    // Read data is sampled on the last strobe cycle, while oe_n is still low.
                    if (wait_cnt == 4'd1) begin
                        mem_we_n <= 1'b1;
                        mem_oe_n <= 1'b1;
                        if (sel_b) begin
                            b_done <= 1'b1;
                            if (!lat_wr) b_rdata <= mem_rdata;
                        end else begin
                            a_done <= 1'b1;
                            if (!lat_wr) a_rdata <= mem_rdata;
                        end
                        state <= HOLD;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                HOLD: begin
                    mem_ce_n  <= 1'b1;
                    mem_ce2   <= 1'b0;
                    mem_lb_n  <= 1'b1;
                    mem_ub_n  <= 1'b1;
                    mem_dq_oe <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_arb_ctrl.sv
// Scoreboard bench for sram_arb_ctrl: main instance at WAIT_CYCLES=2 with an SRAM model,
// plus WAIT_CYCLES=1 and 15 instances for strobe-width and back-to-back timing.
`timescale 1ns/1ps
module tb_sram_arb_ctrl;

    localparam int W_MAIN = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #42 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    logic        a_req, a_wr, b_req, b_wr;
    logic [21:0] a_addr, b_addr;
    logic [15:0] a_wdata, b_wdata;
    logic [1:0]  a_be, b_be;
    logic        a_done, b_done;
    logic [15:0] a_rdata, b_rdata;
    logic        mem_ce_n, mem_ce2, mem_we_n, mem_oe_n, mem_lb_n, mem_ub_n, mem_dq_oe;
    logic [21:0] mem_addr;
    logic [15:0] mem_wdata, mem_rdata;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        bit          port_b;
        bit          chk_data;
        logic [15:0] data;
    } exp_t;
    exp_t sb[$];

    sram_arb_ctrl #(.ADDR_W(22), .DATA_W(16), .WAIT_CYCLES(W_MAIN)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_wr(a_wr), .a_addr(a_addr), .a_wdata(a_wdata), .a_be(a_be),
        .a_done(a_done), .a_rdata(a_rdata),
        .b_req(b_req), .b_wr(b_wr), .b_addr(b_addr), .b_wdata(b_wdata), .b_be(b_be),
        .b_done(b_done), .b_rdata(b_rdata),
        .mem_ce_n(mem_ce_n), .mem_ce2(mem_ce2), .mem_we_n(mem_we_n), .mem_oe_n(mem_oe_n),
        .mem_lb_n(mem_lb_n), .mem_ub_n(mem_ub_n), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_dq_oe(mem_dq_oe), .mem_rdata(mem_rdata)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // SRAM model: 64 words indexed by the low address bits (test addresses are distinct there).
    logic [15:0] sram [64];
    assign mem_rdata = (!mem_ce_n && !mem_oe_n) ? sram[mem_addr[5:0]] : 16'h0000;

    int   we_cnt = 0, oe_cnt = 0;
    bit   prev_ce_n = 1'b1, prev_done = 1'b0;
    logic setup_lb, setup_ub, setup_dq;
    logic [21:0] setup_addr;

    always @(negedge clk) begin : mon_main
        exp_t e;
        if (!mem_ce_n && mem_ce2 && !mem_we_n) begin
            checkOutput("dq_oe_on_write", mem_dq_oe, 1);
            if (!mem_lb_n) sram[mem_addr[5:0]][7:0]  = mem_wdata[7:0];
            if (!mem_ub_n) sram[mem_addr[5:0]][15:8] = mem_wdata[15:8];
        end
        if (!mem_oe_n) checkOutput("dq_oe_on_read", mem_dq_oe, 0);
        if (!rst_n) begin
            we_cnt = 0;
            oe_cnt = 0;
            prev_done = 1'b0;
        end else begin
            if (!mem_we_n) we_cnt++;
            else if (we_cnt > 0) begin checkOutput("we_width", we_cnt, W_MAIN); we_cnt = 0; end
            if (!mem_oe_n) oe_cnt++;
            else if (oe_cnt > 0) begin checkOutput("oe_width", oe_cnt, W_MAIN); oe_cnt = 0; end
            if (!mem_we_n || !mem_oe_n) checkOutput("we_oe_excl", !mem_we_n && !mem_oe_n, 0);
            if (prev_done) checkOutput("ce_gap", mem_ce_n, 1);
            if (!mem_ce_n && prev_ce_n) begin
                setup_lb   = mem_lb_n;
                setup_ub   = mem_ub_n;
                setup_dq   = mem_dq_oe;
                setup_addr = mem_addr;
            end
            if (a_done || b_done) begin
                if (sb.size() == 0) begin
                    checkOutput("done_unexpected", {b_done, a_done}, 0);
                end else begin
                    e = sb.pop_front();
                    checkOutput("done_port", {b_done, a_done}, e.port_b ? 2'b10 : 2'b01);
                    if (e.chk_data) checkOutput("rdata", e.port_b ? b_rdata : a_rdata, e.data);
                end
            end
            prev_done = a_done || b_done;
        end
        prev_ce_n = mem_ce_n;
    end

    task automatic applyStimulus(input bit port_b, input bit wr, input logic [21:0] addr,
                                 input logic [15:0] wdata, input logic [1:0] be,
                                 input logic [15:0] exp_rd);
        int lat = 0;
        bit seen = 1'b0;
        sb.push_back('{port_b: port_b, chk_data: (!wr && be != 2'b00), data: exp_rd});
        if (port_b) begin
            b_req = 1'b1; b_wr = wr; b_addr = addr; b_wdata = wdata; b_be = be;
        end else begin
            a_req = 1'b1; a_wr = wr; a_addr = addr; a_wdata = wdata; a_be = be;
        end
        while (!seen && lat < 64) begin
            @(negedge clk);
            lat++;
            seen = port_b ? b_done : a_done;
        end
        checkOutput(port_b ? "b_latency" : "a_latency", lat, W_MAIN + 2);
        if (!seen && sb.size() > 0) void'(sb.pop_back());
        a_req = 1'b0;
        b_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Sweep instances: port A only, request held high for back-to-back transactions.
    logic        sw_req [2], sw_wr [2], sw_done [2], sw_bdone [2];
    logic        sw_ce_n [2], sw_ce2 [2], sw_we_n [2], sw_oe_n [2], sw_lb_n [2], sw_ub_n [2], sw_dq_oe [2];
    logic [15:0] sw_rdata [2], sw_brdata [2], sw_wdo [2], sw_mdata [2];
    logic [21:0] sw_addr [2];

    for (genvar g = 0; g < 2; g++) begin : g_sw
        localparam int          SW  = (g == 0) ? 1 : 15;
        localparam logic [15:0] PAT = (g == 0) ? 16'h0F0F : 16'hF00F;
        logic [15:0] sw_mem = 16'h0000;
        int  swe = 0, soe = 0, last_done = 0;
        bit  have_prev = 1'b0, pdone = 1'b0;

        assign sw_mdata[g] = (!sw_ce_n[g] && !sw_oe_n[g]) ? sw_mem : 16'h0000;

        sram_arb_ctrl #(.ADDR_W(22), .DATA_W(16), .WAIT_CYCLES(SW)) u_sw (
            .clk(clk), .rst_n(rst_n),
            .a_req(sw_req[g]), .a_wr(sw_wr[g]), .a_addr(22'h000005), .a_wdata(PAT), .a_be(2'b11),
            .a_done(sw_done[g]), .a_rdata(sw_rdata[g]),
            .b_req(1'b0), .b_wr(1'b0), .b_addr(22'h000000), .b_wdata(16'h0000), .b_be(2'b00),
            .b_done(sw_bdone[g]), .b_rdata(sw_brdata[g]),
            .mem_ce_n(sw_ce_n[g]), .mem_ce2(sw_ce2[g]), .mem_we_n(sw_we_n[g]), .mem_oe_n(sw_oe_n[g]),
            .mem_lb_n(sw_lb_n[g]), .mem_ub_n(sw_ub_n[g]), .mem_addr(sw_addr[g]), .mem_wdata(sw_wdo[g]),
            .mem_dq_oe(sw_dq_oe[g]), .mem_rdata(sw_mdata[g])
        );

        always @(negedge clk) begin
            if (!sw_ce_n[g] && !sw_we_n[g]) sw_mem = sw_wdo[g];
            if (!rst_n || !sw_req[g]) begin
                have_prev = 1'b0;
            end
            if (!rst_n) begin
                swe = 0; soe = 0; pdone = 1'b0;
            end else begin
                if (!sw_we_n[g]) swe++;
                else if (swe > 0) begin checkOutput("sw_we_width", swe, SW); swe = 0; end
                if (!sw_oe_n[g]) soe++;
                else if (soe > 0) begin checkOutput("sw_oe_width", soe, SW); soe = 0; end
                if (!sw_we_n[g] || !sw_oe_n[g])
                    checkOutput("sw_we_oe_excl", !sw_we_n[g] && !sw_oe_n[g], 0);
                if (pdone) checkOutput("sw_ce_gap", sw_ce_n[g], 1);
                if (sw_done[g]) begin
                    if (have_prev) checkOutput("sw_done_spacing", cyc - last_done, SW + 3);
                    if (!sw_wr[g]) checkOutput("sw_rdata", sw_rdata[g], PAT);
                    have_prev = 1'b1;
                    last_done = cyc;
                end
                pdone = sw_done[g];
            end
        end
    end

    task automatic runSweep(input int g);
        int n = 0, t = 0;
        sw_req[g] = 1'b1;
        sw_wr[g]  = 1'b1;
        while (n < 6 && t < 400) begin
            @(negedge clk);
            t++;
            if (sw_done[g]) begin
                n++;
                if (n == 3) begin #5 sw_wr[g] = 1'b0; end
            end
        end
        #5 sw_req[g] = 1'b0;
        checkOutput("sw_done_cnt", n, 6);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int n, t;
        for (int i = 0; i < 64; i++) sram[i] = 16'h0000;
        a_req = 0; a_wr = 0; a_addr = '0; a_wdata = '0; a_be = '0;
        b_req = 0; b_wr = 0; b_addr = '0; b_wdata = '0; b_be = '0;
        for (int i = 0; i < 2; i++) begin sw_req[i] = 1'b0; sw_wr[i] = 1'b0; end

        repeat (3) @(negedge clk);
        checkOutput("rst_strobes", {mem_ce_n, mem_ce2, mem_we_n, mem_oe_n, mem_lb_n, mem_ub_n, mem_dq_oe},
                    7'b1011110);
        checkOutput("rst_bus", {mem_addr, mem_wdata[9:0]}, 32'h0);
        checkOutput("rst_ports", {a_done, b_done, a_rdata, b_rdata[13:0]}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        applyStimulus(0, 1, 22'h00000F, 16'hA5A5, 2'b11, 16'h0000);
        applyStimulus(0, 0, 22'h00000F, 16'h0000, 2'b11, 16'hA5A5);
        checkOutput("read_setup_dq_oe", setup_dq, 0);

        applyStimulus(0, 1, 22'h000010, 16'h1234, 2'b11, 16'h0000);
        applyStimulus(0, 1, 22'h000010, 16'hFFFF, 2'b01, 16'h0000);
        checkOutput("be01_lanes", {setup_ub, setup_lb}, 2'b10);
        checkOutput("write_setup_dq_oe", setup_dq, 1);
        applyStimulus(0, 0, 22'h000010, 16'h0000, 2'b11, 16'h12FF);
        applyStimulus(0, 0, 22'h00000F, 16'h0000, 2'b00, 16'h0000);
        checkOutput("be00_lanes", {setup_ub, setup_lb}, 2'b11);

        applyStimulus(1, 1, 22'h3FFFFF, 16'h5A5A, 2'b11, 16'h0000);
        checkOutput("b_max_addr_wr", setup_addr, 22'h3FFFFF);
        applyStimulus(1, 0, 22'h3FFFFF, 16'h0000, 2'b11, 16'h5A5A);
        checkOutput("b_max_addr_rd", setup_addr, 22'h3FFFFF);

        // Abort a write mid-ACCESS: strobes must drop without a clock and no done follows.
        a_req = 1'b1; a_wr = 1'b1; a_addr = 22'h000020; a_wdata = 16'hBEEF; a_be = 2'b11;
        t = 0;
        while (mem_we_n && t < 20) begin @(negedge clk); t++; end
        checkOutput("abort_reached_access", mem_we_n, 0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("abort_strobes", {mem_we_n, mem_ce_n, mem_dq_oe, mem_oe_n}, 4'b1101);
        a_req = 1'b0;
        repeat (2) begin
            @(negedge clk);
            checkOutput("abort_no_done", a_done, 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        applyStimulus(0, 0, 22'h00000F, 16'h0000, 2'b11, 16'hA5A5);

        doReset();
        a_req = 1'b1; a_wr = 1'b1; a_addr = 22'h000001; a_wdata = 16'h1111; a_be = 2'b11;
        b_req = 1'b1; b_wr = 1'b1; b_addr = 22'h000002; b_wdata = 16'h2222; b_be = 2'b11;
        for (int i = 0; i < 4; i++) begin
`ifdef SRAM_ARB_RR_EN
            sb.push_back('{port_b: (i % 2 == 1), chk_data: 1'b0, data: 16'h0000});
`else
            sb.push_back('{port_b: 1'b0, chk_data: 1'b0, data: 16'h0000});
`endif
        end
        n = 0;
        t = 0;
        while (n < 4 && t < 100) begin
            @(negedge clk);
            t++;
            if (a_done || b_done) n++;
        end
        a_req = 1'b0;
        b_req = 1'b0;
        checkOutput("arb_done_cnt", n, 4);
        if (n < 4) sb.delete();
        repeat (2) @(negedge clk);

        runSweep(0);
        runSweep(1);

        checkOutput("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sram_arb_ctrl.md
Name: sram_arb_ctrl

Overview:
- Two-port arbiter and access sequencer for the external 16-bit async SRAM/PSRAM (22-bit word address, active-low ce/we/oe/lb/ub, active-high ce2) on the iceFUN board.
- Port A serves the Arduino DUE bridge; port B serves the on-FPGA test/pattern engine.
- Grants one requester at a time and drives chip strobes with programmable wait states at the 12 MHz system clock.
- Returns read data and a one-cycle done pulse to the requester.

Parameters:
- ADDR_W, 22, SRAM word address width.
- DATA_W, 16, SRAM data width; must be 16 (two byte lanes).
- WAIT_CYCLES, 2, cycles we_n/oe_n are held asserted in ACCESS; legal range 1..15.

Ports:
- clk  in  1  system clock, 12 MHz.
- rst_n  in  1  asynchronous active-low reset.
- a_req  in  1  port A request; held with a_wr/a_addr/a_wdata/a_be stable until a_done.
- a_wr  in  1  1 = write, 0 = read.
- a_addr  in  ADDR_W  word address.
- a_wdata  in  DATA_W  write data.
- a_be  in  2  byte enables: [0] = low byte, [1] = high byte.
- a_done  out  1  one-cycle completion pulse.
- a_rdata  out  DATA_W  read data; valid on a_done, held until the next port-A read completes.
- b_req, b_wr, b_addr, b_wdata, b_be, b_done, b_rdata: same as port A, for port B.
- mem_ce_n  out  1  chip enable, active low.
- mem_ce2  out  1  chip enable 2, active high.
- mem_we_n  out  1  write strobe, active low.
- mem_oe_n  out  1  output enable, active low.
- mem_lb_n  out  1  lower byte select, active low.
- mem_ub_n  out  1  upper byte select, active low.
- mem_addr  out  ADDR_W  address to SRAM.
- mem_wdata  out  DATA_W  data driven to SRAM.
- mem_dq_oe  out  1  1 = top level drives the DQ pads with mem_wdata.
- mem_rdata  in  DATA_W  data from the SRAM pads.

Behaviour:
- Reset (async, immediate): mem_ce_n=1, mem_ce2=0, mem_we_n=1, mem_oe_n=1, mem_lb_n=1, mem_ub_n=1, mem_addr=0, mem_wdata=0, mem_dq_oe=0, a_done=b_done=0, a_rdata=b_rdata=0, arbiter last-grant=B (so A wins first), state=IDLE.
- All outputs are registered.
- FSM states:
  - IDLE: strobes inactive, mem_ce_n=1, mem_ce2=0. If any req is high, arbitrate, latch the winner's wr/addr/wdata/be and port id, then go to SETUP.
  - SETUP (1 cycle): mem_ce_n=0, mem_ce2=1, address valid, lb_n/ub_n = ~be. On writes, mem_dq_oe=1 and data valid. we_n and oe_n stay 1. Load wait counter with WAIT_CYCLES. Go to ACCESS.
  - ACCESS (WAIT_CYCLES cycles): write drives we_n=0; read drives oe_n=0. Counter decrements each cycle. On the last cycle, a read captures mem_rdata into an internal register. Go to HOLD.
  - HOLD (1 cycle): we_n=oe_n=1; ce, addr, data, dq_oe unchanged. Pulse done for the granted port and update its rdata on reads. Go to IDLE.
- Latency from req sampled in IDLE to done: WAIT_CYCLES+2 cycles after the IDLE cycle. One transaction takes WAIT_CYCLES+3 cycles.
- Back-to-back: each transaction returns to IDLE, so ce_n is high for at least 1 cycle between accesses.
- we_n and oe_n are never low together. dq_oe=1 only on writes, in SETUP/ACCESS/HOLD.
- be=2'b00: the access still runs with both lanes deselected. A read returns the captured bus value. done still pulses.
- A req that drops before its done pulse is a protocol violation. The latched copy completes and done still pulses.
- Requests are not queued. A port must see done before starting another request.
- Reset mid-access: strobes deassert immediately, no done pulse, the transaction is lost.

Optional Feature:
- Macro SRAM_ARB_RR_EN.
- Defined: round-robin arbitration. On simultaneous requests the port not granted last wins; the last-grant register updates at each grant.
- Undefined: fixed priority, port A always wins. The last-grant register is not synthesized. Port B can starve under continuous A traffic.

Test Plan:
- WAIT_CYCLES=2: A writes 0xA5A5 to 0x00000F with be=2'b11, then reads 0x00000F. Required: a_rdata=0xA5A5 on a_done; a_done 4 cycles after the IDLE cycle; we_n low exactly 2 cycles.
- Byte lanes: A writes 0x1234 to 0x000010, then writes 0xFFFF with be=2'b01 (lb_n=0, ub_n=1 observed), then reads. Required: 0x12FF.
- Simultaneous a_req/b_req held for 4 transactions. With SRAM_ARB_RR_EN: grants A,B,A,B. Without it: A,A,A,A and b_done stays 0.
- B reads 0x3FFFFF (max address) after its write of 0x5A5A. Required: mem_addr=0x3FFFFF, b_rdata=0x5A5A, a_done stays 0.
- rst_n driven low during ACCESS of a write. Required: mem_we_n=1, mem_ce_n=1, mem_dq_oe=0 in the same delta; no done pulse; next request runs normally.
- Sweep WAIT_CYCLES=1 and 15. Required: oe_n/we_n low width equals WAIT_CYCLES; ce_n high at least 1 cycle between consecutive transactions; oe_n and we_n never low together.
